// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment refresh controller: blank/show digit scan, 4-bit PWM,
// double-buffered digit store loaded via valid/ready, committed at frame boundaries.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   enable              1 = scan, 0 = dark and idle
//   bright[3:0]         PWM duty (bright/16 of SHOW cycles lit)
//   wr_valid/wr_ready   shadow-store write handshake
//   wr_idx, wr_data     digit index and {dp, seg[6:0]} pattern
//   commit              publish shadow store to active store
//   commit_pending      commit requested, not yet applied
//   seg_out, dp_out     segment / decimal-point drive, active-high
//   digit_en            one-hot digit select
//   frame_tick          1-cycle pulse per frame boundary
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 12500,
    parameter int BLANK      = 16,
    parameter int CBITS      = 14,
    parameter int IW         = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [3:0]            bright,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [IW-1:0]         wr_idx,
    input  logic [7:0]            wr_data,
    input  logic                  commit,
    output logic                  commit_pending,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  frame_tick
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_SHOW
    } state_t;

    localparam logic [CBITS-1:0] BLANK_LAST = CBITS'(BLANK - 1);
    localparam logic [CBITS-1:0] DWELL_LAST = CBITS'(DWELL - 1);
    localparam logic [IW-1:0]    IDX_LAST   = IW'(NUM_DIGITS - 1);

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CBITS-1:0]      phase_q, phase_d;
    logic [3:0]            pwm_q, pwm_d;
    logic                  pending_q, pending_d;
    logic [7:0]            shadow_q [NUM_DIGITS];
    logic [7:0]            shadow_d [NUM_DIGITS];
    logic [7:0]            active_q [NUM_DIGITS];
    logic [7:0]            active_d [NUM_DIGITS];

    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] den_q, den_d;
    logic                  tick_q, tick_d;

    logic                  boundary;
    logic                  wr_fire;
    logic                  apply;

    assign wr_ready       = !pending_q;
    assign commit_pending = pending_q;
    assign seg_out        = seg_q;
    assign dp_out         = dp_q;
    assign digit_en       = den_q;
    assign frame_tick     = tick_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            phase_q   <= '0;
            pwm_q     <= '0;
            pending_q <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            seg_q     <= '0;
            dp_q      <= 1'b0;
            den_q     <= '0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            phase_q   <= phase_d;
            pwm_q     <= pwm_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            den_q     <= den_d;
            tick_q    <= tick_d;
        end
    end

    // Next-state: scan sequencing. enable=0 always wins and restarts at digit 0.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        phase_d  = phase_q;
        pwm_d    = pwm_q;
        boundary = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_BLANK;
                    idx_d   = '0;
                    phase_d = '0;
                end
            end
            S_BLANK: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    phase_d = '0;
                end else if (phase_q == BLANK_LAST) begin
                    state_d = S_SHOW;
                    phase_d = '0;
                    pwm_d   = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_SHOW: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    phase_d = '0;
                end else begin
                    pwm_d = pwm_q + 1'b1;
                    if (phase_q == DWELL_LAST) begin
                        state_d  = S_BLANK;
                        phase_d  = '0;
                        boundary = (idx_q == IDX_LAST);
                        idx_d    = boundary ? '0 : idx_q + 1'b1;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
                phase_d = '0;
            end
        endcase
    end

    // Store update. Writes are blocked while a commit is pending, so the
    // shadow copied into the active store is exactly what was committed.
    always_comb begin
        wr_fire  = wr_valid && wr_ready;
        apply    = pending_q && ((state_q == S_IDLE) || boundary);
        shadow_d = shadow_q;
        active_d = active_q;
        if (wr_fire && (32'(wr_idx) < NUM_DIGITS)) begin
            shadow_d[wr_idx] = wr_data;
        end
        if (apply) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q || commit;
        end
    end

    // Output drive, registered. Dropping enable blanks the pads immediately.
    always_comb begin
        seg_d  = '0;
        dp_d   = 1'b0;
        den_d  = '0;
        tick_d = boundary;
        if ((state_q == S_SHOW) && enable) begin
            den_d = NUM_DIGITS'(1) << idx_q;
            if (pwm_q < bright) begin
                seg_d = active_q[idx_q][6:0];
                dp_d  = active_q[idx_q][7];
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: frame-position reference model feeds an
// expectation queue, a negedge monitor pops and compares every cycle.
module tb_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int BL    = 2;
    localparam int P     = DW + BL;
    localparam int FRAME = N * P;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] bright;
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_idx;
    logic [7:0] wr_data;
    logic       commit;
    logic       commit_pending;
    logic [6:0] seg_out;
    logic       dp_out;
    logic [3:0] digit_en;
    logic       frame_tick;

    seg_scan_ctrl #(
        .NUM_DIGITS(N), .DWELL(DW), .BLANK(BL), .CBITS(4), .IW(2)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .bright(bright),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx),
        .wr_data(wr_data), .commit(commit),
        .commit_pending(commit_pending), .seg_out(seg_out),
        .dp_out(dp_out), .digit_en(digit_en), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] den;
        logic       ft;
        logic       rdy;
        logic       pend;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: position t within the frame, counted from the first
    // BLANK cycle of digit 0.
    bit         run;
    int         t;
    bit         m_pend;
    logic [7:0] m_sh  [N];
    logic [7:0] m_act [N];

    task automatic step();
        exp_t e;
        int   d, o, pw;
        bit   bnd;
        e   = '0;
        bnd = 0;
        if (rst) begin
            run    = 0;
            t      = 0;
            m_pend = 0;
            for (int i = 0; i < N; i++) begin
                m_sh[i]  = '0;
                m_act[i] = '0;
            end
            e.rdy = 1'b1;
        end else begin
            if (run && enable) begin
                d = t / P;
                o = t % P;
                if (o >= BL) begin
                    pw    = (o - BL) % 16;
                    e.den = 4'(1 << d);
                    if (pw < int'(bright)) begin
                        e.seg = m_act[d][6:0];
                        e.dp  = m_act[d][7];
                    end
                end
                bnd = (t == FRAME - 1);
            end
            e.ft = bnd;
            if (wr_valid && !m_pend && int'(wr_idx) < N)
                m_sh[wr_idx] = wr_data;
            if (m_pend && (!run || bnd)) begin
                m_act  = m_sh;
                m_pend = 0;
            end else if (commit) begin
                m_pend = 1;
            end
            if (!run) begin
                if (enable) begin
                    run = 1;
                    t   = 0;
                end
            end else if (!enable) begin
                run = 0;
            end else begin
                t = (t + 1) % FRAME;
            end
            e.rdy  = !m_pend;
            e.pend = m_pend;
        end
        q.push_back(e);
    endtask

    task automatic tick();
        step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("seg_out", 8'(seg_out), 8'(e.seg));
                chk("dp_out", 8'(dp_out), 8'(e.dp));
                chk("digit_en", 8'(digit_en), 8'(e.den));
                chk("frame_tick", 8'(frame_tick), 8'(e.ft));
                chk("wr_ready", 8'(wr_ready), 8'(e.rdy));
                chk("commit_pending", 8'(commit_pending), 8'(e.pend));
            end
        end
    end

    logic [7:0] pat [4] = '{8'h3F, 8'h06, 8'h5B, 8'h4F};

    initial begin : driver
        rst      = 1'b1;
        enable   = 1'b0;
        bright   = 4'd15;
        wr_valid = 1'b0;
        wr_idx   = '0;
        wr_data  = '0;
        commit   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        enable = 1'b1;
        repeat (90) tick();

        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_idx   = 2'(i);
            wr_data  = pat[i];
            tick();
        end
        wr_valid = 1'b0;
        commit   = 1'b1;
        tick();
        commit = 1'b0;
        repeat (90) tick();

        bright = 4'd4;
        repeat (45) tick();
        bright = 4'd0;
        repeat (45) tick();
        bright = 4'd15;
        repeat (27) tick();

        enable = 1'b0;
        repeat (5) tick();
        enable = 1'b1;
        repeat (50) tick();

        enable   = 1'b0;
        repeat (3) tick();
        wr_valid = 1'b1;
        wr_idx   = 2'd1;
        wr_data  = 8'h80;
        tick();
        wr_valid = 1'b0;
        commit   = 1'b1;
        tick();
        commit   = 1'b0;
        wr_valid = 1'b1;
        wr_idx   = 2'd3;
        wr_data  = 8'h55;
        tick();
        wr_valid = 1'b0;
        repeat (4) tick();

        enable = 1'b1;
        repeat (15) tick();
        wr_valid = 1'b1;
        wr_idx   = 2'd2;
        wr_data  = 8'hFF;
        commit   = 1'b1;
        tick();
        wr_valid = 1'b0;
        commit   = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (60) tick();

        for (int k = 0; k < 4000; k++) begin
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            if ($urandom_range(0, 59) == 0) bright = 4'($urandom_range(0, 15));
            wr_valid = ($urandom_range(0, 2) == 0);
            wr_idx   = 2'($urandom_range(0, 3));
            wr_data  = 8'($urandom);
            commit   = ($urandom_range(0, 49) == 0);
            tick();
        end
        rst      = 1'b0;
        wr_valid = 1'b0;
        commit   = 1'b0;

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
